// File: rtl/lsu_mem_stage.sv
// Load/store unit MEM stage: issues one data-memory access at a time over a
// req/gnt/rvalid handshake and produces the registered MEM/WB results.

package riscv_pkg;
  typedef enum logic [3:0] {
    LSU_NONE, LSU_LB, LSU_LH, LSU_LW, LSU_LD, LSU_LBU, LSU_LHU, LSU_LWU,
    LSU_SB, LSU_SH, LSU_SW, LSU_SD
  } lsu_op_t;
endpackage

module lsu_mem_stage
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   alu_result_i,
  input  logic [63:0]   store_data_i,
  input  logic [4:0]    rd_addr_i,
  input  logic          reg_write_i,
  input  logic          mem_to_reg_i,
  input  lsu_op_t       lsu_op_i,
  input  logic          mem_read_i,
  input  logic          mem_write_i,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [63:0]   dmem_addr_o,
  output logic [63:0]   dmem_wdata_o,
  output logic [7:0]    dmem_be_o,
  input  logic          dmem_gnt_i,
  input  logic          dmem_rvalid_i,
  input  logic [63:0]   dmem_rdata_i,
  output logic          stall_o,
  output logic          misaligned_o,
  output logic [63:0]   wb_data_o,
  output logic [4:0]    rd_addr_o,
  output logic          reg_write_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_next;
  logic        mem_op, mis, issue;
  logic [2:0]  off;
  logic [7:0]  size_mask;
  logic [63:0] shifted, load_result;
  logic        unused_mem_to_reg;

  assign mem_op            = mem_read_i | mem_write_i;
  assign off               = alu_result_i[2:0];
  assign issue             = (state == IDLE) & mem_op & !mis;
  assign unused_mem_to_reg = mem_to_reg_i;

  always_comb begin
    size_mask = 8'h00;
    mis       = 1'b0;
    case (lsu_op_i)
      LSU_LB, LSU_LBU, LSU_SB: size_mask = 8'h01;
      LSU_LH, LSU_LHU, LSU_SH: begin size_mask = 8'h03; mis = off[0];    end
      LSU_LW, LSU_LWU, LSU_SW: begin size_mask = 8'h0F; mis = |off[1:0]; end
      LSU_LD, LSU_SD:          begin size_mask = 8'hFF; mis = |off;      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue) state_next = dmem_gnt_i ? WAIT : REQ;
      REQ:     if (dmem_gnt_i) state_next = WAIT;
      WAIT:    if (dmem_rvalid_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields come straight from the held EX/MEM inputs, so they stay put in REQ.
  always_comb begin
    dmem_req_o   = !rst & (issue | (state == REQ));
    stall_o      = !rst & (issue | (state == REQ) | ((state == WAIT) & !dmem_rvalid_i));
    dmem_we_o    = !rst & mem_write_i;
    dmem_addr_o  = {alu_result_i[63:3], 3'b000};
    dmem_be_o    = rst ? 8'h00 : (size_mask << off);
    dmem_wdata_o = (rst | !mem_write_i) ? 64'd0 : (store_data_i << {off, 3'b000});
  end

  assign shifted = dmem_rdata_i >> {off, 3'b000};

  always_comb begin
    load_result = shifted;
    case (lsu_op_i)
      LSU_LB:  load_result = {{56{shifted[7]}},  shifted[7:0]};
      LSU_LH:  load_result = {{48{shifted[15]}}, shifted[15:0]};
      LSU_LW:  load_result = {{32{shifted[31]}}, shifted[31:0]};
      LSU_LBU: load_result = {56'd0, shifted[7:0]};
      LSU_LHU: load_result = {48'd0, shifted[15:0]};
      LSU_LWU: load_result = {32'd0, shifted[31:0]};
      default: load_result = shifted;
    endcase
  end

  // Stalled cycles insert a bubble; a misaligned access drops its writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_o    <= 64'd0;
      rd_addr_o    <= 5'd0;
      reg_write_o  <= 1'b0;
      misaligned_o <= 1'b0;
    end else begin
      misaligned_o <= (state == IDLE) & mem_op & mis;
      if (stall_o) begin
        reg_write_o <= 1'b0;
      end else if ((state == WAIT) & dmem_rvalid_i) begin
        wb_data_o   <= mem_read_i ? load_result : alu_result_i;
        rd_addr_o   <= rd_addr_i;
        reg_write_o <= reg_write_i & mem_read_i;
      end else if ((state == IDLE) & !mem_op) begin
        wb_data_o   <= alu_result_i;
        rd_addr_o   <= rd_addr_i;
        reg_write_o <= reg_write_i;
      end else begin
        reg_write_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed, table-driven bench for lsu_mem_stage with a small handshake
// responder plus hand sequences for misalignment and reset during WAIT.

module tb_lsu_mem_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] alu_result_i, store_data_i, dmem_rdata_i;
  logic [4:0]  rd_addr_i;
  logic        reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i;
  lsu_op_t     lsu_op_i;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic        dmem_req_o, dmem_we_o, stall_o, misaligned_o, reg_write_o;
  logic [63:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
  logic [7:0]  dmem_be_o;
  logic [4:0]  rd_addr_o;

  int checks = 0;
  int failures = 0;

  lsu_mem_stage dut (
    .clk(clk), .rst(rst),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
    .lsu_op_i(lsu_op_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .misaligned_o(misaligned_o),
    .wb_data_o(wb_data_o), .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    lsu_op_t     op;
    logic [63:0] addr, sdata, rdata;
    logic [4:0]  rd;
    logic        rw;
    int          gnt_dly, rv_dly;
    logic [7:0]  be;
    logic [63:0] wdata, wb;
    logic [4:0]  rd_exp;
    logic        rw_exp, mis_exp;
    int          req_exp, stall_exp;
  } vec_t;

  vec_t vecs[16];

  function automatic logic isLoad(input lsu_op_t op);
    return op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LD, LSU_LBU, LSU_LHU, LSU_LWU};
  endfunction

  function automatic logic isStore(input lsu_op_t op);
    return op inside {LSU_SB, LSU_SH, LSU_SW, LSU_SD};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input lsu_op_t op, input logic [63:0] addr, input logic [63:0] sdata,
                               input logic [4:0] rd, input logic rw);
    lsu_op_i     = op;
    alu_result_i = addr;
    store_data_i = sdata;
    rd_addr_i    = rd;
    reg_write_i  = rw;
    mem_read_i   = isLoad(op);
    mem_write_i  = isStore(op);
    mem_to_reg_i = isLoad(op);
  endtask

  // Drives one operation, acting as memory: grant after gnt_dly request cycles,
  // respond after rv_dly wait cycles.
  task automatic runOp(input vec_t v, input int idx);
    logic granted, gnt_now, done;
    int   req_cnt, stall_cnt, wait_cnt;
    granted = 0; done = 0; req_cnt = 0; stall_cnt = 0; wait_cnt = 0;
    @(negedge clk);
    applyStimulus(v.op, v.addr, v.sdata, v.rd, v.rw);
    dmem_rdata_i = v.rdata;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      dmem_rvalid_i = granted && (wait_cnt == v.rv_dly);
      dmem_gnt_i    = 1'b0;
      #1;
      if (dmem_req_o) begin
        if (req_cnt == 0) begin
          checkOutput($sformatf("v%0d_addr", idx), dmem_addr_o, v.addr & ~64'h7);
          checkOutput($sformatf("v%0d_be", idx), {56'd0, dmem_be_o}, {56'd0, v.be});
          checkOutput($sformatf("v%0d_wdata", idx), dmem_wdata_o, v.wdata);
          checkOutput($sformatf("v%0d_we", idx), {63'd0, dmem_we_o}, {63'd0, isStore(v.op)});
        end
        dmem_gnt_i = (req_cnt == v.gnt_dly);
        req_cnt++;
      end
      if (stall_o) stall_cnt++;
      else         done = 1;
      gnt_now = dmem_req_o && dmem_gnt_i;
      @(posedge clk);
      if (granted) wait_cnt++;
      if (gnt_now) granted = 1;
    end
    #1;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    checkOutput($sformatf("v%0d_done", idx), {63'd0, done}, 64'd1);
    checkOutput($sformatf("v%0d_req_cycles", idx), req_cnt, v.req_exp);
    checkOutput($sformatf("v%0d_stall_cycles", idx), stall_cnt, v.stall_exp);
    checkOutput($sformatf("v%0d_wb_data", idx), wb_data_o, v.wb);
    checkOutput($sformatf("v%0d_rd_addr", idx), {59'd0, rd_addr_o}, {59'd0, v.rd_exp});
    checkOutput($sformatf("v%0d_reg_write", idx), {63'd0, reg_write_o}, {63'd0, v.rw_exp});
    checkOutput($sformatf("v%0d_misaligned", idx), {63'd0, misaligned_o}, {63'd0, v.mis_exp});
  endtask

  initial begin
    //          op        addr        sdata                rdata                rd  rw gnt rv  be     wdata                wb                   rdx rwx mis req stall
    vecs[0]  = '{LSU_NONE, 64'h1234, 64'h0,               64'h0,               5,  1, 0, 0, 8'h00, 64'h0,               64'h1234,            5,  1,  0,  0,  0};
    vecs[1]  = '{LSU_LB,   64'h1003, 64'h0,               64'h80000000,        7,  1, 0, 2, 8'h08, 64'h0,               64'hFFFFFFFFFFFFFF80, 7,  1,  0,  1,  3};
    vecs[2]  = '{LSU_SH,   64'h2006, 64'hBEEF,            64'h0,               3,  1, 3, 0, 8'hC0, 64'hBEEF000000000000, 64'h2006,            3,  0,  0,  4,  4};
    vecs[3]  = '{LSU_LW,   64'h3002, 64'h0,               64'h0,               4,  1, 0, 0, 8'h00, 64'h0,               64'h2006,            3,  0,  1,  0,  0};
    vecs[4]  = '{LSU_LWU,  64'h4004, 64'h0,               64'hF000000000000000, 9, 1, 0, 0, 8'hF0, 64'h0,               64'h00000000F0000000, 9,  1,  0,  1,  1};
    vecs[5]  = '{LSU_LH,   64'h1002, 64'h0,               64'h0000000080010000, 10, 1, 1, 1, 8'h0C, 64'h0,              64'hFFFFFFFFFFFF8001, 10, 1,  0,  2,  3};
    vecs[6]  = '{LSU_LHU,  64'h1002, 64'h0,               64'h0000000080010000, 11, 1, 0, 0, 8'h0C, 64'h0,              64'h0000000000008001, 11, 1,  0,  1,  1};
    vecs[7]  = '{LSU_LW,   64'h5004, 64'h0,               64'h8765432100000000, 12, 1, 0, 0, 8'hF0, 64'h0,              64'hFFFFFFFF87654321, 12, 1,  0,  1,  1};
    vecs[8]  = '{LSU_LD,   64'h6000, 64'h0,               64'hDEADBEEFCAFEF00D, 13, 1, 0, 0, 8'hFF, 64'h0,              64'hDEADBEEFCAFEF00D, 13, 1,  0,  1,  1};
    vecs[9]  = '{LSU_SB,   64'h7005, 64'hAB,              64'h0,               14, 1, 0, 0, 8'h20, 64'h0000AB0000000000, 64'h7005,            14, 0,  0,  1,  1};
    vecs[10] = '{LSU_SW,   64'h7004, 64'hCAFEBABE,        64'h0,               15, 0, 0, 0, 8'hF0, 64'hCAFEBABE00000000, 64'h7004,            15, 0,  0,  1,  1};
    vecs[11] = '{LSU_SD,   64'h8000, 64'h0123456789ABCDEF, 64'h0,              16, 0, 0, 0, 8'hFF, 64'h0123456789ABCDEF, 64'h8000,            16, 0,  0,  1,  1};
    vecs[12] = '{LSU_SD,   64'h8004, 64'h1,               64'h0,               2,  1, 0, 0, 8'h00, 64'h0,               64'h8000,            16, 0,  1,  0,  0};
    vecs[13] = '{LSU_LBU,  64'h9007, 64'h0,               64'hFE00000000000000, 17, 1, 0, 0, 8'h80, 64'h0,              64'h00000000000000FE, 17, 1,  0,  1,  1};
    vecs[14] = '{LSU_NONE, 64'hABCD, 64'h0,               64'h0,               18, 0, 0, 0, 8'h00, 64'h0,               64'hABCD,            18, 0,  0,  0,  0};
    vecs[15] = '{LSU_LH,   64'h1001, 64'h0,               64'h0,               19, 1, 0, 0, 8'h00, 64'h0,               64'hABCD,            18, 0,  1,  0,  0};

    rst = 1'b1;
    applyStimulus(LSU_LW, 64'h40, 64'h0, 5'd1, 1'b1);
    dmem_rdata_i  = 64'h0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req", {63'd0, dmem_req_o}, 64'd0);
    checkOutput("rst_stall", {63'd0, stall_o}, 64'd0);
    checkOutput("rst_be", {56'd0, dmem_be_o}, 64'd0);
    checkOutput("rst_wb_data", wb_data_o, 64'd0);
    checkOutput("rst_reg_write", {63'd0, reg_write_o}, 64'd0);
    checkOutput("rst_misaligned", {63'd0, misaligned_o}, 64'd0);
    applyStimulus(LSU_NONE, 64'h0, 64'h0, 5'd0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) runOp(vecs[i], i);

    // Misaligned flag lasts only one cycle once the offending op is gone.
    @(negedge clk);
    applyStimulus(LSU_NONE, 64'h77, 64'h0, 5'd22, 1'b1);
    @(posedge clk); #1;
    checkOutput("mis_one_cycle", {63'd0, misaligned_o}, 64'd0);
    checkOutput("mis_next_wb", wb_data_o, 64'h77);

    // Reset while waiting for a response; the late response must be dropped.
    @(negedge clk);
    applyStimulus(LSU_LW, 64'h4000, 64'h0, 5'd20, 1'b1);
    dmem_gnt_i = 1'b1;
    #1;
    checkOutput("wr_req", {63'd0, dmem_req_o}, 64'd1);
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    #1;
    checkOutput("wr_wait_stall", {63'd0, stall_o}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("wr_rst_req", {63'd0, dmem_req_o}, 64'd0);
    checkOutput("wr_rst_stall", {63'd0, stall_o}, 64'd0);
    checkOutput("wr_rst_we_be", {55'd0, dmem_we_o, dmem_be_o}, 64'd0);
    checkOutput("wr_rst_wdata", dmem_wdata_o, 64'd0);
    @(posedge clk); #1;
    checkOutput("wr_rst_wb_data", wb_data_o, 64'd0);
    checkOutput("wr_rst_rd_addr", {59'd0, rd_addr_o}, 64'd0);
    checkOutput("wr_rst_reg_write", {63'd0, reg_write_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(LSU_NONE, 64'h11, 64'h0, 5'd23, 1'b0);
    #1;
    checkOutput("wr_after_stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    applyStimulus(LSU_NONE, 64'h66, 64'h0, 5'd24, 1'b1);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 64'hFFFFFFFFFFFFFFFF;
    #1;
    checkOutput("wr_late_rvalid_stall", {63'd0, stall_o}, 64'd0);
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    checkOutput("wr_late_wb_data", wb_data_o, 64'h66);
    checkOutput("wr_late_rd_addr", {59'd0, rd_addr_o}, 64'd24);
    checkOutput("wr_late_reg_write", {63'd0, reg_write_o}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
